// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RV32 5-stage pipeline hazard controller
// Stall/flush/forward control with a data-memory miss FSM, miss timeout and stall-cycle counter.
module hazard_ctrl #(
    parameter logic [1:0] LOAD_SRC = 2'b01,
    parameter int         MAX_WAIT = 64,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic [1:0]       ResultSrcE,
    input  logic             PcTakenE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MISS_WAIT = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [WW-1:0] wait_cnt;
    logic          miss_stall;
    logic          lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RegWriteM && RdM != 5'd0 && RdM == rs)
            return 2'b10;
        else if (RegWriteW && RdW != 5'd0 && RdW == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= RUN;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            RUN:       if (MemReqM && !MemReadyM) next_state = MISS_WAIT;
            MISS_WAIT: if (MemReadyM) next_state = FILL;
            FILL:      next_state = RUN;
            default:   next_state = RUN;
        endcase
    end

    // The miss is stalled in the very cycle it is seen, before the FSM has moved.
    assign miss_stall = (state == RUN && MemReqM && !MemReadyM) ||
                        state == MISS_WAIT || state == FILL;
    assign lw_stall   = (ResultSrcE == LOAD_SRC) && RdE != 5'd0 &&
                        (RdE == Rs1D || RdE == Rs2D);

    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (rst_n) begin
            ForwardAE = fwd_sel(Rs1E);
            ForwardBE = fwd_sel(Rs2E);
            if (miss_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                // FILL lets the returned read data land in M/W.
                FlushW = (state != FILL);
            end else if (PcTakenE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            if (state == RUN && next_state == MISS_WAIT)
                wait_cnt <= '0;
            else if (state == MISS_WAIT && wait_cnt != WAIT_LIM)
                wait_cnt <= wait_cnt + 1'b1;
            if (state == MISS_WAIT && wait_cnt == WAIT_LIM - 1'b1)
                mem_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (StallF && stall_cycles != {CNT_W{1'b1}})
            stall_cycles <= stall_cycles + 1'b1;
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int MAX_WAIT = 64;
    localparam int CNT_W    = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic             RegWriteM, RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PcTakenE, MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct {
        string            tag;
        logic [11:0]      ctrl;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb[$];
    int               n_assert = 0;
    int               n_fail   = 0;
    logic [CNT_W-1:0] mcnt     = '0;
    logic [11:0]      obs_ctrl;
    logic [11:0]      missv;
    logic [11:0]      fillv;

    hazard_ctrl #(.LOAD_SRC(2'b01), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PcTakenE(PcTakenE),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    assign obs_ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
                       ForwardAE, ForwardBE, mem_timeout};

    function automatic logic [11:0] c(input logic sf, sd, se, sm, fd, fe, fw,
                                      input logic [1:0] fa, fb, input logic to);
        return {sf, sd, se, sm, fd, fe, fw, fa, fb, to};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PcTakenE = 0;
        MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic check(input string tag, input logic [11:0] ctrl, input bit wait_edge);
        exp_t e;
        e.tag = tag; e.ctrl = ctrl; e.cnt = mcnt;
        sb.push_back(e);
        if (wait_edge) @(negedge clk); else #1;
        e = sb.pop_front();
        n_assert++;
        assert (obs_ctrl === e.ctrl) else begin
            n_fail++;
            $error("FAIL %s ctrl: observed %b expected %b", e.tag, obs_ctrl, e.ctrl);
        end
        n_assert++;
        assert (stall_cycles === e.cnt) else begin
            n_fail++;
            $error("FAIL %s stall_cycles: observed %0d expected %0d", e.tag, stall_cycles, e.cnt);
        end
        if (e.ctrl[11] && mcnt != {CNT_W{1'b1}}) mcnt = mcnt + 1'b1;
    endtask

    initial begin
        missv = c(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 0);
        fillv = c(1, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0);
        clear_inputs();
        rst_n = 1'b0;
        Rs1E = 5; RdM = 5; RegWriteM = 1; PcTakenE = 1; MemReqM = 1;
        check("reset", 12'h000, 1);
        tick();
        clear_inputs();
        rst_n = 1'b1;
        check("idle", 12'h000, 1);
        tick();

        ResultSrcE = 2'b01; RdE = 5; Rs1D = 5;
        check("lw_rs1", c(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0), 1);
        tick();
        ResultSrcE = 0; RdE = 0; Rs1D = 0; RdM = 5; RegWriteM = 1; Rs1E = 5;
        check("fwd_a_mem", c(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), 1);
        tick();
        RdM = 0; RegWriteM = 0; Rs1E = 0; ResultSrcE = 2'b01; RdE = 0; Rs1D = 0;
        check("lw_x0", 12'h000, 1);
        tick();
        RdE = 9; Rs2D = 9;
        check("lw_rs2", c(1, 1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0), 1);
        tick();
        ResultSrcE = 2'b10;
        check("not_load", 12'h000, 1);
        tick();
        clear_inputs();

        RdM = 7; RdW = 7; RegWriteM = 1; RegWriteW = 1; Rs2E = 7; Rs1E = 7;
        check("fwd_mem_pri", c(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b10, 0), 1);
        tick();
        RegWriteM = 0;
        check("fwd_wb", c(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0), 1);
        tick();
        RegWriteM = 1; Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0;
        check("fwd_x0", 12'h000, 1);
        tick();
        clear_inputs();

        PcTakenE = 1;
        check("branch", c(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), 1);
        tick();
        ResultSrcE = 2'b01; RdE = 3; Rs1D = 3;
        check("branch_over_lw", c(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), 1);
        tick();
        clear_inputs();

        MemReqM = 1; MemReadyM = 0;
        check("miss_detect", missv, 1);
        tick();
        check("miss_wait1", missv, 1);
        tick();
        check("miss_wait2", missv, 1);
        tick();
        MemReadyM = 1;
        check("miss_ready", missv, 1);
        tick();
        MemReqM = 0; MemReadyM = 0;
        check("miss_fill", fillv, 1);
        tick();
        check("after_fill", 12'h000, 1);
        tick();
        MemReqM = 1; MemReadyM = 1;
        check("hit", 12'h000, 1);
        tick();
        clear_inputs();

        MemReqM = 1; MemReadyM = 0; PcTakenE = 1;
        check("br_miss_detect", missv, 1);
        tick();
        MemReadyM = 1;
        check("br_miss_ready", missv, 1);
        tick();
        MemReqM = 0; MemReadyM = 0;
        check("br_miss_fill", fillv, 1);
        tick();
        check("br_after_fill", c(0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0), 1);
        tick();
        clear_inputs();

        MemReqM = 1; MemReadyM = 0;
        for (int i = 0; i < MAX_WAIT + 3; i++) begin
            check($sformatf("timeout_%0d", i),
                  c(1, 1, 1, 1, 0, 0, 1, 2'b00, 2'b00, (i >= MAX_WAIT + 1)), 1);
            tick();
        end
        #2;
        rst_n = 1'b0;
        mcnt  = '0;
        check("async_rst", 12'h000, 0);
        tick();
        rst_n = 1'b1;
        MemReqM = 0;
        check("post_rst_run", 12'h000, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RV32 core.
- Drives stall/flush enables for the F/D, D/E, E/M and M/W pipeline registers, and forwarding selects for the Execute-stage ALU operands.
- Sequences data-memory miss stalls with a small FSM.
- Provides a miss-timeout flag and a saturating stall-cycle performance counter.

Parameters:
- LOAD_SRC, 2'b01, ResultSrcE encoding that identifies a load in Execute.
- MAX_WAIT, 64, MISS_WAIT cycle count at which mem_timeout sets.
- CNT_W, 32, width of stall_cycles.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
Rs1D  in  5  rs1 of instruction in Decode
Rs2D  in  5  rs2 of instruction in Decode
Rs1E  in  5  rs1 in Execute
Rs2E  in  5  rs2 in Execute
RdE  in  5  rd in Execute
RdM  in  5  rd in Memory
RdW  in  5  rd in Writeback
RegWriteM  in  1  Memory-stage instruction writes rd
RegWriteW  in  1  Writeback-stage instruction writes rd
ResultSrcE  in  2  result select of Execute instruction
PcTakenE  in  1  branch/jump resolved taken in Execute
MemReqM  in  1  data-memory access issued in Memory stage
MemReadyM  in  1  data memory has completed the access
StallF  out  1  hold PC
StallD  out  1  hold F/D register
StallE  out  1  hold D/E register
StallM  out  1  hold E/M register
FlushD  out  1  clear F/D to NOP
FlushE  out  1  clear D/E control to NOP
FlushW  out  1  insert bubble into M/W
ForwardAE  out  2  ALU A select: 00 RD1E, 01 ResultW, 10 ALUResultM
ForwardBE  out  2  ALU B select, same encoding
mem_timeout  out  1  sticky: miss exceeded MAX_WAIT
stall_cycles  out  CNT_W  saturating count of cycles with StallF=1

Behaviour:
- Reset (rst_n=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_cycles=0. While rst_n=0, all stall, flush and forward outputs are 0.
- FSM states: RUN, MISS_WAIT, FILL.
  - RUN -> MISS_WAIT when MemReqM && !MemReadyM.
  - MISS_WAIT -> FILL when MemReadyM.
  - FILL -> RUN unconditionally; FILL lasts 1 cycle so the M/W register captures the returned read data.
- miss_stall = (state==RUN && MemReqM && !MemReadyM) || state==MISS_WAIT || state==FILL.
  - Asserted combinationally in the same cycle the miss is seen.
  - A hit (MemReqM && MemReadyM in RUN) costs 0 cycles.
- During miss_stall:
  - StallF=StallD=StallE=StallM=1.
  - FlushW=1, except in FILL where FlushW=0.
  - FlushD=FlushE=0.
  - Load-use and branch flush are suppressed. Their inputs stay frozen, so they take effect on the first RUN cycle after FILL.
- Load-use, when not in miss_stall: lw_stall = (ResultSrcE==LOAD_SRC) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
  - lw_stall gives StallF=StallD=1 and FlushE=1 for exactly 1 cycle (the load then advances).
- Branch, when not in miss_stall: PcTakenE gives FlushD=FlushE=1 with no stall.
  - PcTakenE and lw_stall cannot coincide, since a load in Execute is not a branch. If both are seen, flush takes priority: StallF=StallD=0, FlushD=FlushE=1.
- Forwarding is combinational and independent of the stall state:
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00.
  - Memory stage has priority over Writeback. x0 is never forwarded.
  - ForwardBE uses the same rules with Rs2E.
- wait_cnt:
  - Clears on entry to MISS_WAIT and increments each MISS_WAIT cycle.
  - Saturates at MAX_WAIT.
  - When it reaches MAX_WAIT, mem_timeout sets, stays set until reset, and the FSM keeps waiting.
- stall_cycles:
  - Increments on every clock edge where StallF=1 (miss or load-use).
  - Saturates at all-ones and never wraps.
- Reset asserted mid-miss: state returns to RUN immediately; stall outputs drop asynchronously.

Test Plan:
1. Load-use: ResultSrcE=01, RdE=5, Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle; next cycle RdM=5, RegWriteM=1, Rs1E=5 -> ForwardAE=10. Repeat with RdE=0 -> no stall.
2. Forward priority: RdM=RdW=7, both RegWrite=1, Rs2E=7 -> ForwardBE=10; drop RegWriteM -> 01; Rs2E=0 with RdM=RdW=0 -> 00.
3. Branch: PcTakenE=1 in RUN -> FlushD=FlushE=1, StallF=0, stall_cycles unchanged.
4. Miss: MemReqM=1, MemReadyM=0 for 3 cycles then 1 -> all stalls=1 for 5 cycles (RUN-detect cycle + 2 further MISS_WAIT cycles + ready cycle + FILL cycle), FlushW=1 except in FILL, stall_cycles=5.
5. Miss overlapping branch: PcTakenE=1 during a miss -> FlushD/FlushE=0 through FILL, then 1 on the first RUN cycle.
6. Timeout/reset: MemReadyM held 0 for MAX_WAIT+2 cycles -> mem_timeout=1 and stays 1; pulse rst_n=0 mid-miss -> all outputs 0 and state RUN without waiting for a clock edge.
